rprelu_param_loader: RTL and testbench

- Writer side of the RPReLU per-channel parameter interface. Receives a serial configuration word stream and assembles the beta, gamma and zeta arrays used by the RPReLU layer.
- Double-buffered. Words are assembled in shadow registers. The active arrays, which drive the RPReLU layer, change only on a commit. A commit happens when the stream is complete and the datapath is not holding.
- Sits between the configuration/DMA front end and the RPReLU stage of each residual layer.

---
 rtl/rprelu_pkg.sv | 21 ++
 rtl/rprelu_param_bank.sv | 37 +++
 rtl/rprelu_param_loader.sv | 137 +++++++++++++
 tb/tb_rprelu_param_loader.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/rprelu_pkg.sv
// rtl/rprelu_pkg.sv - shared types and constants for the RPReLU parameter loader
package rprelu_pkg;

    localparam int PARA_WIDTH_DEFAULT = 16;

    typedef enum logic [1:0] {
        IDLE        = 2'd0,
        LOAD        = 2'd1,
        COMMIT_WAIT = 2'd2
    } state_t;

    localparam logic [1:0] SEL_BETA  = 2'd0;
    localparam logic [1:0] SEL_GAMMA = 2'd1;
    localparam logic [1:0] SEL_ZETA  = 2'd2;

    // Index width that stays legal for a single-channel build.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rprelu_param_bank.sv
// rtl/rprelu_param_bank.sv - shadow/active register bank for one parameter array
module rprelu_param_bank
    import rprelu_pkg::*;
#(
    parameter int PARA_WIDTH  = PARA_WIDTH_DEFAULT,
    parameter int CHANNEL_NUM = 128,
    localparam int CH_W       = idx_width(CHANNEL_NUM)
) (
    input  logic                         clk,
    input  logic                         rstn,
    input  logic                         wr_en,
    input  logic [CH_W-1:0]              wr_idx,
    input  logic signed [PARA_WIDTH-1:0] wr_data,
    input  logic                         commit,
    output logic signed [PARA_WIDTH-1:0] active [0:CHANNEL_NUM-1]
);

    logic signed [PARA_WIDTH-1:0] shadow [0:CHANNEL_NUM-1];

    always_ff @(posedge clk) begin
        if (!rstn) begin
            for (int i = 0; i < CHANNEL_NUM; i++) begin
                shadow[i] <= '0;
                active[i] <= '0;
            end
        end else begin
            if (wr_en) begin
                shadow[wr_idx] <= wr_data;
            end
            // Commit never coincides with a write: writes only occur while loading.
            if (commit) begin
                active <= shadow;
            end
        end
    end

endmodule

// File: rtl/rprelu_param_loader.sv
// rtl/rprelu_param_loader.sv - serial loader for double-buffered RPReLU beta/gamma/zeta arrays
module rprelu_param_loader
    import rprelu_pkg::*;
#(
    parameter int PARA_WIDTH  = PARA_WIDTH_DEFAULT,
    parameter int CHANNEL_NUM = 128
) (
    input  logic                         clk,
    input  logic                         rstn,
    input  logic                         load_start,
    input  logic                         cfg_valid,
    output logic                         cfg_ready,
    input  logic signed [PARA_WIDTH-1:0] cfg_data,
    input  logic                         hold_in,
    output logic signed [PARA_WIDTH-1:0] rprelu_beta  [0:CHANNEL_NUM-1],
    output logic signed [PARA_WIDTH-1:0] rprelu_gamma [0:CHANNEL_NUM-1],
    output logic signed [PARA_WIDTH-1:0] rprelu_zeta  [0:CHANNEL_NUM-1],
    output logic                         param_valid,
    output logic                         load_busy,
    output logic                         load_done
);

    localparam int              CH_W    = idx_width(CHANNEL_NUM);
    localparam logic [CH_W-1:0] CH_LAST = CH_W'(CHANNEL_NUM - 1);

    state_t          state, state_n;
    logic [CH_W-1:0] ch_cnt, ch_cnt_n;
    logic [1:0]      arr_sel, arr_sel_n;
    logic            handshake;
    logic            commit;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state       <= IDLE;
            ch_cnt      <= '0;
            arr_sel     <= SEL_BETA;
            cfg_ready   <= 1'b0;
            load_busy   <= 1'b0;
            load_done   <= 1'b0;
            param_valid <= 1'b0;
        end else begin
            state       <= state_n;
            ch_cnt      <= ch_cnt_n;
            arr_sel     <= arr_sel_n;
            cfg_ready   <= (state_n == LOAD);
            load_busy   <= (state_n != IDLE);
            load_done   <= commit;
            param_valid <= param_valid | commit;
        end
    end

    always_comb begin
        state_n   = state;
        ch_cnt_n  = ch_cnt;
        arr_sel_n = arr_sel;
        handshake = 1'b0;
        commit    = 1'b0;
        case (state)
            IDLE: begin
                if (load_start) begin
                    state_n   = LOAD;
                    ch_cnt_n  = '0;
                    arr_sel_n = SEL_BETA;
                end
            end
            LOAD: begin
                // A restart wins over a word presented on the same edge; that word is dropped.
                if (load_start) begin
                    ch_cnt_n  = '0;
                    arr_sel_n = SEL_BETA;
                end else if (cfg_valid && cfg_ready) begin
                    handshake = 1'b1;
                    if (ch_cnt == CH_LAST) begin
                        ch_cnt_n = '0;
                        if (arr_sel == SEL_ZETA) begin
                            arr_sel_n = SEL_BETA;
                            state_n   = COMMIT_WAIT;
                        end else begin
                            arr_sel_n = arr_sel + 2'd1;
                        end
                    end else begin
                        ch_cnt_n = ch_cnt + CH_W'(1);
                    end
                end
            end
            COMMIT_WAIT: begin
                if (!hold_in) begin
                    commit  = 1'b1;
                    state_n = IDLE;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    rprelu_param_bank #(
        .PARA_WIDTH  (PARA_WIDTH),
        .CHANNEL_NUM (CHANNEL_NUM)
    ) u_beta_bank (
        .clk     (clk),
        .rstn    (rstn),
        .wr_en   (handshake && (arr_sel == SEL_BETA)),
        .wr_idx  (ch_cnt),
        .wr_data (cfg_data),
        .commit  (commit),
        .active  (rprelu_beta)
    );

    rprelu_param_bank #(
        .PARA_WIDTH  (PARA_WIDTH),
        .CHANNEL_NUM (CHANNEL_NUM)
    ) u_gamma_bank (
        .clk     (clk),
        .rstn    (rstn),
        .wr_en   (handshake && (arr_sel == SEL_GAMMA)),
        .wr_idx  (ch_cnt),
        .wr_data (cfg_data),
        .commit  (commit),
        .active  (rprelu_gamma)
    );

    rprelu_param_bank #(
        .PARA_WIDTH  (PARA_WIDTH),
        .CHANNEL_NUM (CHANNEL_NUM)
    ) u_zeta_bank (
        .clk     (clk),
        .rstn    (rstn),
        .wr_en   (handshake && (arr_sel == SEL_ZETA)),
        .wr_idx  (ch_cnt),
        .wr_data (cfg_data),
        .commit  (commit),
        .active  (rprelu_zeta)
    );

endmodule

// File: tb/tb_rprelu_param_loader.sv
// tb/tb_rprelu_param_loader.sv - self-checking bench for rprelu_param_loader
module tb_rprelu_param_loader;

    localparam int W = 16;
    localparam int N = 4;
    localparam int T = 3 * N;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    logic load_start = 1'b0;
    logic cfg_valid = 1'b0;
    logic hold_in = 1'b0;
    logic signed [W-1:0] cfg_data = '0;
    logic cfg_ready, param_valid, load_busy, load_done;
    logic signed [W-1:0] beta  [0:N-1];
    logic signed [W-1:0] gamma [0:N-1];
    logic signed [W-1:0] zeta  [0:N-1];

    always #5 clk = ~clk;

    rprelu_param_loader #(
        .PARA_WIDTH  (W),
        .CHANNEL_NUM (N)
    ) dut (
        .clk          (clk),
        .rstn         (rstn),
        .load_start   (load_start),
        .cfg_valid    (cfg_valid),
        .cfg_ready    (cfg_ready),
        .cfg_data     (cfg_data),
        .hold_in      (hold_in),
        .rprelu_beta  (beta),
        .rprelu_gamma (gamma),
        .rprelu_zeta  (zeta),
        .param_valid  (param_valid),
        .load_busy    (load_busy),
        .load_done    (load_done)
    );

    int n_cmp = 0;
    int n_err = 0;
    bit chk_en = 1'b0;
    int ready_cycles = 0;
    logic signed [W-1:0] stim [$];

    // Transaction-level model: mode 0 idle, 1 accepting words, 2 awaiting commit.
    int m_mode = 0;
    int m_cnt = 0;
    bit m_valid = 1'b0;
    bit m_done = 1'b0;
    logic signed [W-1:0] m_shadow [0:T-1];
    logic signed [W-1:0] m_active [0:T-1];

    always @(posedge clk) begin
        if (!rstn) begin
            m_mode  <= 0;
            m_cnt   <= 0;
            m_valid <= 1'b0;
            m_done  <= 1'b0;
            for (int i = 0; i < T; i++) begin
                m_shadow[i] <= '0;
                m_active[i] <= '0;
            end
        end else begin
            m_done <= 1'b0;
            if (m_mode == 0) begin
                if (load_start) begin
                    m_mode <= 1;
                    m_cnt  <= 0;
                end
            end else if (m_mode == 1) begin
                if (load_start) begin
                    m_cnt <= 0;
                end else if (cfg_valid) begin
                    m_shadow[m_cnt] <= cfg_data;
                    m_cnt <= m_cnt + 1;
                    if (m_cnt == T - 1) m_mode <= 2;
                end
            end else if (!hold_in) begin
                m_active <= m_shadow;
                m_valid  <= 1'b1;
                m_done   <= 1'b1;
                m_mode   <= 0;
            end
        end
    end

    task automatic chk(input string name, input int idx, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s[%0d] got %h want %h at %0t", name, idx, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("cfg_ready", 0, W'(cfg_ready), W'(m_mode == 1));
            chk("load_busy", 0, W'(load_busy), W'(m_mode != 0));
            chk("load_done", 0, W'(load_done), W'(m_done));
            chk("param_valid", 0, W'(param_valid), W'(m_valid));
            for (int i = 0; i < N; i++) begin
                chk("beta", i, beta[i], m_active[i]);
                chk("gamma", i, gamma[i], m_active[N + i]);
                chk("zeta", i, zeta[i], m_active[2 * N + i]);
            end
            if (cfg_ready) ready_cycles++;
        end
    end

    task automatic fill(input int n, input int base, input int step);
        stim.delete();
        for (int i = 0; i < n; i++) stim.push_back(W'(base + step * i));
    endtask

    task automatic start_load();
        @(negedge clk);
        load_start = 1'b1;
    endtask

    task automatic send(input int gap_pct, input string tag);
        int i;
        int budget;
        i = 0;
        budget = 600;
        while (i < stim.size() && budget > 0) begin
            @(negedge clk);
            load_start = 1'b0;
            cfg_valid  = ($urandom_range(0, 99) >= gap_pct);
            cfg_data   = stim[i];
            if (cfg_valid && cfg_ready) i++;
            budget--;
        end
        chk(tag, 0, W'(i), W'(stim.size()));
        @(negedge clk);
        cfg_valid  = 1'b0;
        load_start = 1'b0;
    endtask

    initial begin
        repeat (2) @(negedge clk);
        chk("rst_param_valid", 0, W'(param_valid), '0);
        chk("rst_cfg_ready", 0, W'(cfg_ready), '0);
        chk("rst_load_busy", 0, W'(load_busy), '0);
        chk("rst_load_done", 0, W'(load_done), '0);
        chk("rst_beta", 0, beta[0], '0);
        rstn = 1'b1;
        chk_en = 1'b1;

        // Reset in the middle of a load
        start_load();
        fill(5, 100, 1);
        send(0, "midload_sent");
        rstn = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
        chk("midrst_busy", 0, W'(load_busy), '0);
        chk("midrst_ready", 0, W'(cfg_ready), '0);
        chk("midrst_valid", 0, W'(param_valid), '0);

        // Basic load 1..12 with continuous valid
        ready_cycles = 0;
        start_load();
        fill(T, 1, 1);
        send(0, "basic_sent");
        chk("basic_done_early", 0, W'(load_done), '0);
        chk("basic_ready_off", 0, W'(cfg_ready), '0);
        @(negedge clk);
        chk("basic_done", 0, W'(load_done), W'(1));
        chk("basic_valid", 0, W'(param_valid), W'(1));
        for (int i = 0; i < N; i++) begin
            chk("basic_beta", i, beta[i], W'(i + 1));
            chk("basic_gamma", i, gamma[i], W'(i + 5));
            chk("basic_zeta", i, zeta[i], W'(i + 9));
        end
        @(negedge clk);
        chk("basic_done_pulse", 0, W'(load_done), '0);
        chk("basic_ready_cycles", 0, W'(ready_cycles), W'(12));

        // Commit deferred by hold_in
        hold_in = 1'b1;
        start_load();
        fill(T, 21, 1);
        send(0, "hold_sent");
        repeat (10) begin
            chk("hold_done", 0, W'(load_done), '0);
            chk("hold_beta0", 0, beta[0], W'(1));
            chk("hold_zeta3", 0, zeta[3], W'(12));
            @(negedge clk);
        end
        hold_in = 1'b0;
        @(negedge clk);
        chk("hold_commit_done", 0, W'(load_done), W'(1));
        chk("hold_beta0_new", 0, beta[0], W'(21));
        chk("hold_zeta3_new", 0, zeta[3], W'(32));

        // Restart after six words; the word beside load_start is dropped
        start_load();
        fill(6, 40, 1);
        send(0, "pre_restart_sent");
        load_start = 1'b1;
        cfg_valid  = 1'b1;
        cfg_data   = 16'sh7FFF;
        fill(T, -1, -1);
        send(0, "restart_sent");
        @(negedge clk);
        chk("restart_done", 0, W'(load_done), W'(1));
        for (int i = 0; i < N; i++) begin
            chk("restart_beta", i, beta[i], W'(-(i + 1)));
            chk("restart_gamma", i, gamma[i], W'(-(i + 5)));
            chk("restart_zeta", i, zeta[i], W'(-(i + 9)));
        end

        // Stray valid in IDLE, then throttled reload with held commit
        repeat (6) begin
            @(negedge clk);
            cfg_valid = 1'b1;
            cfg_data  = 16'sh1234;
            chk("stray_ready", 0, W'(cfg_ready), '0);
        end
        @(negedge clk);
        cfg_valid = 1'b0;
        chk("stray_beta0", 0, beta[0], W'(-1));
        hold_in = 1'b1;
        start_load();
        stim.delete();
        stim.push_back(16'sh8000); stim.push_back(16'sh7FFF); stim.push_back(16'sh0001); stim.push_back(16'shFFFF);
        stim.push_back(16'sh1357); stim.push_back(16'sh2468); stim.push_back(16'shA5A5); stim.push_back(16'h5A5A);
        stim.push_back(16'sh0F0F); stim.push_back(16'shF0F0); stim.push_back(16'sh4000); stim.push_back(16'shC000);
        send(50, "throttle_sent");
        chk("reload_old_beta0", 0, beta[0], W'(-1));
        repeat (3) begin
            @(negedge clk);
            cfg_valid  = 1'b1;
            load_start = 1'b1;
            chk("cw_ready", 0, W'(cfg_ready), '0);
        end
        @(negedge clk);
        cfg_valid  = 1'b0;
        load_start = 1'b0;
        hold_in    = 1'b0;
        @(negedge clk);
        chk("throttle_done", 0, W'(load_done), W'(1));
        for (int i = 0; i < N; i++) begin
            chk("throttle_beta", i, beta[i], stim[i]);
            chk("throttle_gamma", i, gamma[i], stim[N + i]);
            chk("throttle_zeta", i, zeta[i], stim[2 * N + i]);
        end

        repeat (3) @(negedge clk);
        chk_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

endmodule
